dslot_ip_controller: RTL

- Sequencing controller for one 25-input online (MSD-first, signed-digit) inner-product datapath: serial-parallel multipliers feeding an online adder tree.
- Clears the datapath, gates and indexes the serial input digits, waits out the online delay, then captures the output digit stream into a result register.
- Applies ReLU to the result and, optionally, stops early once the output is known to be negative.
- Sits between the layer scheduler (start/done) and one inner-product datapath instance.

---
 rtl/dslot_ip_controller.sv | 138 +++++++++++++
 1 files changed

// File: rtl/dslot_ip_controller.sv
// Sequencing controller for a 25-input online (MSD-first) inner-product datapath.
// Optional early negative termination: define DSLOT_EARLY_TERM_EN.
module dslot_ip_controller #(
  parameter int unsigned N_DIGITS     = 8,
  parameter int unsigned OUT_DIGITS   = 16,
  parameter int unsigned ONLINE_DELAY = 5,
  parameter int unsigned CW           = $clog2(ONLINE_DELAY + OUT_DIGITS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        z_p,
  input  logic                        z_n,
  output logic                        ip_rst,
  output logic                        x_en,
  output logic [$clog2(N_DIGITS)-1:0] x_idx,
  output logic                        busy,
  output logic                        done,
  output logic                        neg,
  output logic [OUT_DIGITS-1:0]       relu_out
);

  localparam int unsigned IW = $clog2(N_DIGITS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CLR  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]            state, state_nxt;
  logic [CW-1:0]         cyc, cyc_nxt;
  logic [OUT_DIGITS-1:0] res_p, res_p_nxt;
  logic [OUT_DIGITS-1:0] res_n, res_n_nxt;
  logic                  seen_nz, seen_nz_nxt;
  logic                  neg_nxt;
  logic [OUT_DIGITS-1:0] relu_nxt;
  logic                  d_pos, d_neg;

`ifdef DSLOT_EARLY_TERM_EN
  logic early, early_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cyc      <= '0;
      res_p    <= '0;
      res_n    <= '0;
      seen_nz  <= 1'b0;
      neg      <= 1'b0;
      relu_out <= '0;
    end else begin
      state    <= state_nxt;
      cyc      <= cyc_nxt;
      res_p    <= res_p_nxt;
      res_n    <= res_n_nxt;
      seen_nz  <= seen_nz_nxt;
      neg      <= neg_nxt;
      relu_out <= relu_nxt;
    end
  end

`ifdef DSLOT_EARLY_TERM_EN
  always_ff @(posedge clk) begin
    if (rst) early <= 1'b0;
    else     early <= early_nxt;
  end
`endif

  // Redundant zero (11) collapses to 0 on both rails.
  assign d_pos = z_p & ~z_n;
  assign d_neg = z_n & ~z_p;

  always_comb begin
    state_nxt   = state;
    cyc_nxt     = cyc;
    res_p_nxt   = res_p;
    res_n_nxt   = res_n;
    seen_nz_nxt = seen_nz;
    neg_nxt     = neg;
    relu_nxt    = relu_out;
`ifdef DSLOT_EARLY_TERM_EN
    early_nxt   = early;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt   = S_CLR;
          res_p_nxt   = '0;
          res_n_nxt   = '0;
          seen_nz_nxt = 1'b0;
          neg_nxt     = 1'b0;
          relu_nxt    = '0;
`ifdef DSLOT_EARLY_TERM_EN
          early_nxt   = 1'b0;
`endif
        end
      end
      S_CLR: begin
        cyc_nxt   = '0;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        cyc_nxt = cyc + CW'(1);
        if (cyc >= CW'(ONLINE_DELAY)) begin
          res_p_nxt = {res_p[OUT_DIGITS-2:0], d_pos};
          res_n_nxt = {res_n[OUT_DIGITS-2:0], d_neg};
          // The first nonzero digit dominates the sign of an MSD-first result.
          if (!seen_nz && (d_pos || d_neg)) begin
            seen_nz_nxt = 1'b1;
            neg_nxt     = d_neg;
`ifdef DSLOT_EARLY_TERM_EN
            if (d_neg) begin
              state_nxt = S_DONE;
              early_nxt = 1'b1;
            end
`endif
          end
          if (cyc == CW'(ONLINE_DELAY + OUT_DIGITS - 1)) state_nxt = S_DONE;
        end
        if (state_nxt == S_DONE) relu_nxt = neg_nxt ? '0 : (res_p_nxt - res_n_nxt);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef DSLOT_EARLY_TERM_EN
  assign ip_rst = rst | (state == S_CLR) | ((state == S_DONE) & early);
`else
  assign ip_rst = rst | (state == S_CLR);
`endif

  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);
  assign x_en  = (state == S_RUN) && (cyc < CW'(N_DIGITS));
  assign x_idx = x_en ? IW'(cyc) : '0;

endmodule
